conv_fmap_collector: RTL
========================

Name: conv_fmap_collector

Overview:
Receiving end of the convolution result stream. Accepts the En-qualified signed accumulator samples produced by a 3x3 convolution stage for one IMG x IMG feature map. Applies ReLU, requantisation and saturation, and stores each frame in a local buffer. Drains the stored frame in raster order over a valid/ready interface to the next layer (pooling/dense) at pixel width WO.

Parameters:
W3, 21, input accumulator width (signed), matches convolution output width
WO, 9, output pixel width (signed; values always >= 0 after ReLU)
SHIFT, 8, arithmetic right shift applied after ReLU (requantisation)
IMG, 7, feature map side; frame = IMG*IMG samples (49)
AW, 6, buffer address width; must satisfy 2**AW >= IMG*IMG

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_data  in  W3  signed convolution result, sampled when in_en=1
in_en  in  1  input sample qualifier, no backpressure toward source
out_data  out  WO  signed requantised pixel, registered
out_valid  out  1  out_data valid
out_ready  in  1  downstream accept; transfer when out_valid & out_ready
out_last  out  1  high with the final (IMG*IMG-1) pixel of a frame
frame_done  out  1  one-cycle pulse after the last pixel transfer
overflow  out  1  sticky: a sample arrived while not collecting
busy  out  1  high in DRAIN state

Behaviour:
- Reset (rst=1 at clk edge): state=COLLECT, wr_cnt=0, rd_cnt=0, out_valid=0, out_last=0, out_data=0, frame_done=0, overflow=0. Buffer contents are not cleared and are don't-care. Reset mid-frame or mid-drain abandons that frame. No partial output is emitted.
- Pixel transform, combinational on in_data:
  - r = (in_data < 0) ? 0 : in_data.
  - q = r >>> SHIFT (truncating).
  - If q > 2**(WO-1)-1, q is clamped to 2**(WO-1)-1 (255 at defaults).
  - The stored value is q[WO-1:0].
- COLLECT state:
  - Each cycle with in_en=1 writes the transformed sample at address wr_cnt, then wr_cnt++.
  - Gaps in in_en pause collection. Counting is not reset by gaps.
  - When the write at wr_cnt = IMG*IMG-1 occurs, next state is DRAIN and wr_cnt returns to 0.
- DRAIN state:
  - out_valid rises on the first cycle in DRAIN, with out_data = buffer[0]. Latency from the 49th accepted sample to out_valid is 2 clock edges.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - On each transfer, rd_cnt++ and the next word is presented the following cycle. Back-to-back transfers at one per cycle are supported with out_ready held high.
  - out_last=1 exactly when rd_cnt = IMG*IMG-1.
  - On the last transfer: out_valid=0 next cycle, frame_done=1 for one cycle, rd_cnt=0, state=COLLECT. A sample arriving on the cycle frame_done is high is accepted as pixel 0 of the next frame.
- in_en=1 while in DRAIN, including on the cycle of the last transfer: sample dropped, overflow set to 1. overflow holds until rst.
- in_en and out_ready never interact in COLLECT; out_ready is ignored when out_valid=0.
- Buffer: single port (2**AW) x WO register array or inferred RAM with synchronous read. Reads must respect the hold-under-backpressure rule.

Test Plan:
- Frame of 49 samples, in_en continuous, in_data = k*256 (k=0..48), out_ready=1 -> out_data 0..48 in order over 49 consecutive cycles, out_last only on value 48, frame_done pulses once on the cycle after, overflow=0.
- Transform corners at defaults: -5000 -> 0; 1000 -> 3; 65535 -> 255; 65536 -> 255 (clamp); 1048575 -> 255; 255 -> 0.
- Backpressure: out_ready pattern 1,0,0,1,0,1,... across the frame -> out_data/out_last stable whenever out_valid & !out_ready; all 49 values delivered once, in order.
- Input gaps: 49 samples with in_en toggling 1,0 -> identical output to continuous case; DRAIN starts only after the 49th sample.
- Overflow: assert in_en for 3 cycles during DRAIN -> those samples absent from all output; overflow=1 and stays 1. The next full frame drains correctly.
- Reset mid-collect: 20 samples, rst=1 for one cycle, then 49 new samples -> only the new frame is output. Reset during DRAIN -> out_valid=0 next cycle, no frame_done.

Source files
------------

// File: rtl/conv_fmap_collector.sv
// conv_fmap_collector
//   Receiving end of the 3x3 convolution result stream. Each qualified
//   accumulator sample is passed through ReLU, an arithmetic right shift
//   and a saturating clamp, then written into a local frame buffer. Once a
//   full IMG x IMG frame has been collected, the buffer is drained in raster
//   order over a valid/ready interface to the next layer.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   in_data    : signed convolution result, sampled when in_en = 1
//   in_en      : input sample qualifier (no backpressure toward the source)
//   out_data   : requantised pixel, registered
//   out_valid  : out_data is valid
//   out_ready  : downstream accept; a transfer is out_valid & out_ready
//   out_last   : high with the final pixel of the frame
//   frame_done : one-cycle pulse after the last pixel transfer
//   overflow   : sticky, a sample arrived while not collecting
//   busy       : high while draining
module conv_fmap_collector #(
  parameter int W3    = 21,
  parameter int WO    = 9,
  parameter int SHIFT = 8,
  parameter int IMG   = 7,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W3-1:0] in_data,
  input  logic          in_en,
  output logic [WO-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          frame_done,
  output logic          overflow,
  output logic          busy
);

  localparam logic            ST_COLLECT = 1'b0;
  localparam logic            ST_DRAIN   = 1'b1;
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(IMG*IMG-1);
  localparam logic [W3-1:0]   QMAX       = W3'((1 << (WO-1)) - 1);

  logic            state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [WO-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            frame_done_q, frame_done_d;
  logic            overflow_q, overflow_d;

  logic [WO-1:0]   mem_q [2**AW];
  logic            wr_en;
  logic [AW-1:0]   rd_next;

  logic [W3-1:0]   relu;
  logic [W3-1:0]   shifted;
  logic [WO-1:0]   pix;

  // Pixel transform: negative accumulators become zero, the rest are
  // requantised by a truncating shift and saturated to the largest
  // positive value that fits a signed WO-bit pixel.
  always_comb begin
    relu    = in_data[W3-1] ? '0 : in_data;
    shifted = relu >> SHIFT;
    pix     = (shifted > QMAX) ? QMAX[WO-1:0] : shifted[WO-1:0];
  end

  // Next-state logic. rd_cnt always names the pixel currently presented
  // on out_data, so out_last is simply "rd_cnt is the final address".
  // The first DRAIN cycle has out_valid low; it is used to load pixel 0
  // into the output register. After that the register only reloads on a
  // transfer, which keeps data and last stable under backpressure.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q | (in_en & (state_q == ST_DRAIN));
    wr_en        = 1'b0;
    rd_next      = rd_cnt_q + 1'b1;

    case (state_q)
      ST_COLLECT: begin
        if (in_en) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LAST_ADDR) begin
            wr_cnt_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (!out_valid_q) begin
          out_data_d  = mem_q[rd_cnt_q];
          out_last_d  = (rd_cnt_q == LAST_ADDR);
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          if (rd_cnt_q == LAST_ADDR) begin
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            frame_done_d = 1'b1;
            rd_cnt_d     = '0;
            state_d      = ST_COLLECT;
          end else begin
            rd_cnt_d   = rd_next;
            out_data_d = mem_q[rd_next];
            out_last_d = (rd_next == LAST_ADDR);
          end
        end
      end
    endcase
  end

  // Control and output registers with synchronous reset; a reset abandons
  // whatever frame was being collected or drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Frame buffer. Contents survive reset; they are always rewritten
  // before being read back.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_cnt_q] <= pix;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == ST_DRAIN);

endmodule
